// File: rtl/seg_pkg.sv
// Shared glyph constants, digit-code encoding and code-to-segment decode for the display.
package seg_pkg;

    // Digit code: 0-15 hex value, 16 dash, 17 blank.
    typedef logic [4:0] digit_t;

    localparam digit_t DIG_DASH  = 5'd16;
    localparam digit_t DIG_BLANK = 5'd17;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLY_0     = 7'h3F;
    localparam logic [6:0] GLY_1     = 7'h06;
    localparam logic [6:0] GLY_2     = 7'h5B;
    localparam logic [6:0] GLY_3     = 7'h4F;
    localparam logic [6:0] GLY_4     = 7'h66;
    localparam logic [6:0] GLY_5     = 7'h6D;
    localparam logic [6:0] GLY_6     = 7'h7D;
    localparam logic [6:0] GLY_7     = 7'h07;
    localparam logic [6:0] GLY_8     = 7'h7F;
    localparam logic [6:0] GLY_9     = 7'h6F;
    localparam logic [6:0] GLY_A     = 7'h77;
    localparam logic [6:0] GLY_B     = 7'h7C;
    localparam logic [6:0] GLY_C     = 7'h39;
    localparam logic [6:0] GLY_D     = 7'h5E;
    localparam logic [6:0] GLY_E     = 7'h79;
    localparam logic [6:0] GLY_F     = 7'h71;
    localparam logic [6:0] GLY_DASH  = 7'h40;
    localparam logic [6:0] GLY_BLANK = 7'h00;

    function automatic logic [6:0] glyph(digit_t code);
        logic [6:0] g;
        case (code)
            5'd0:     g = GLY_0;
            5'd1:     g = GLY_1;
            5'd2:     g = GLY_2;
            5'd3:     g = GLY_3;
            5'd4:     g = GLY_4;
            5'd5:     g = GLY_5;
            5'd6:     g = GLY_6;
            5'd7:     g = GLY_7;
            5'd8:     g = GLY_8;
            5'd9:     g = GLY_9;
            5'd10:    g = GLY_A;
            5'd11:    g = GLY_B;
            5'd12:    g = GLY_C;
            5'd13:    g = GLY_D;
            5'd14:    g = GLY_E;
            5'd15:    g = GLY_F;
            DIG_DASH: g = GLY_DASH;
            default:  g = GLY_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, DATA_W steps total.
module bin2bcd_seq #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic [DATA_W-1:0]                 value_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [4*((DATA_W+2)/3)-1:0]       bcd_o
);
    import seg_pkg::*;

    localparam int unsigned BCD_D = (DATA_W + 2) / 3;
    localparam int unsigned BCD_W = 4 * BCD_D;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BCD_W-1:0]  adj;
    logic [BCD_W-1:0]  bcd_shift;

    // Add-3 correction on every BCD digit, then shift in the next binary bit.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(BCD_D); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_shift = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
    end

    // Start a new conversion when idle; otherwise step until the shift count runs out.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        if (!busy_q) begin
            if (start_i) begin
                busy_d = 1'b1;
                cnt_d  = CNT_W'(DATA_W);
                bin_d  = value_i;
                bcd_d  = '0;
            end
        end else begin
            bin_d = bin_q << 1;
            bcd_d = bcd_shift;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
        end
    end

    // Conversion state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            bin_q  <= '0;
            bcd_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
        end
    end

    // done_o marks the final step; bcd_o is the result that step produces.
    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CNT_W'(1));
    assign bcd_o  = bcd_shift;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment controller: hex or decimal display buffer with scanned, registered pins.
module seg_scan_display #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SCAN_DIV    = 100000,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          AN_ACT_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              load_i,
    input  logic              mode_i,
    input  logic              blank_lz_i,
    output logic [6:0]        seg_o,
    output logic [DIGITS-1:0] an_o,
    output logic              busy_o,
    output logic              ovf_o
);
    import seg_pkg::*;

    localparam int unsigned BUF_W = 4 * DIGITS;
    localparam int unsigned BCD_W = 4 * ((DATA_W + 2) / 3);
    localparam int unsigned HEX_W = (DATA_W > BUF_W) ? DATA_W : BUF_W;
    localparam int unsigned DEC_W = (BCD_W > BUF_W) ? BCD_W : BUF_W;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    logic             conv_busy, conv_done, accept;
    logic [BCD_W-1:0] conv_bcd;
    logic [HEX_W-1:0] hex_ext;
    logic [DEC_W-1:0] dec_ext;

    logic [BUF_W-1:0] disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic             blank_q, blank_d;
    logic             blank_pend_q, blank_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic [3:0]  cur_nib;
    logic        upper_nz;
    digit_t      code;

    assign accept = load_i && !conv_busy;

    bin2bcd_seq #(
        .DATA_W (DATA_W)
    ) u_bin2bcd (
        .clk_i   (clk),
        .rst_ni  (rst),
        .start_i (accept && mode_i),
        .value_i (data_i),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    assign hex_ext = HEX_W'(data_i);
    assign dec_ext = DEC_W'(conv_bcd);

    // Buffer commit: hex straight away, decimal on the final conversion step.
    always_comb begin
        disp_d       = disp_q;
        ovf_d        = ovf_q;
        blank_d      = blank_q;
        blank_pend_d = blank_pend_q;
        if (accept && !mode_i) begin
            disp_d  = hex_ext[BUF_W-1:0];
            ovf_d   = |(hex_ext >> BUF_W);
            blank_d = blank_lz_i;
        end else if (accept && mode_i) begin
            blank_pend_d = blank_lz_i;
        end else if (conv_done) begin
            disp_d  = dec_ext[BUF_W-1:0];
            ovf_d   = |(dec_ext >> BUF_W);
            blank_d = blank_pend_q;
        end
    end

    // Prescaler and scan index; the index steps once per SCAN_DIV cycles.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Pick the digit code for the index about to be shown, including dash and blanking.
    always_comb begin
        cur_nib  = '0;
        upper_nz = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IDX_W'(i) == idx_d) cur_nib = disp_q[4*i +: 4];
            if (IDX_W'(i) >= idx_d && disp_q[4*i +: 4] != 4'd0) upper_nz = 1'b1;
        end
        if (ovf_q)                                  code = DIG_DASH;
        else if (blank_q && idx_d != '0 && !upper_nz) code = DIG_BLANK;
        else                                        code = {1'b0, cur_nib};
        seg_d = SEG_ACT_LOW ? ~glyph(code) : glyph(code);
        an_d  = AN_ACT_LOW ? ~(DIGITS'(1) << idx_d) : (DIGITS'(1) << idx_d);
    end

    // Display buffer, scan state and registered pin drivers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_q       <= '0;
            ovf_q        <= 1'b0;
            blank_q      <= 1'b0;
            blank_pend_q <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            seg_q        <= {7{SEG_ACT_LOW}};
            an_q         <= {DIGITS{AN_ACT_LOW}};
        end else begin
            disp_q       <= disp_d;
            ovf_q        <= ovf_d;
            blank_q      <= blank_d;
            blank_pend_q <= blank_pend_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg_o  = seg_q;
    assign an_o   = an_q;
    assign busy_o = conv_busy;
    assign ovf_o  = ovf_q;

endmodule
